glyph_fetch_scheduler: RTL and testbench

Sequences the single shared text/font RAM port for glyph-mode video. It sits between the sync generator (`hpos`/`vpos`/`display_on`) and the RAM. For each 8-pixel character cell it prefetches the character code, then the font row, and loads them into a pixel shift register. All RAM slots not needed for display are given to a host read/write requester.

---
 rtl/glyph_fetch_scheduler.sv | 149 ++++++++++++++
 tb/tb_glyph_fetch_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_fetch_scheduler.sv
// Shares one text/font RAM port between glyph-mode display fetch and a host requester.
// Each 8-clock cell slot fetches the next cell's code and font row, then reloads the pixel shifter.
module glyph_fetch_scheduler #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_TOTAL   = 1344,
  parameter int V_ACTIVE  = 768,
  parameter int V_TOTAL   = 806,
  parameter int COLS      = 128,
  parameter int CELL_H    = 16,
  parameter int ADDR_W    = 14,
  parameter int TEXT_BASE = 0,
  parameter int FONT_BASE = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       hpos,
  input  logic [9:0]        vpos,
  input  logic              display_on,
  output logic              pixel_on,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [7:0]        host_rdata,
  output logic [2:0]        slot_state
);

  localparam int COL_SH = $clog2(COLS);
  localparam int ROW_SH = $clog2(CELL_H);

  typedef enum logic [2:0] {
    FREE     = 3'd0,
    TXT_ADDR = 3'd1,
    TXT_DATA = 3'd2,
    FNT_ADDR = 3'd3,
    FNT_DATA = 3'd4
  } slot_e;

  // Host handshake: host_req/host_we/host_addr/host_wdata are held until host_ack,
  // host_ack pulses in the cycle the RAM access happens, and a granted read returns
  // host_rvalid/host_rdata exactly one cycle later.

  logic [2:0]        phase;
  logic              win_line;
  logic              win_next;
  logic              active;
  logic [9:0]        tgt_line;
  logic [COL_SH-1:0] tgt_col;
  logic [ADDR_W-1:0] txt_addr;
  logic [ADDR_W-1:0] fnt_addr;
  slot_e             slot;

  logic [7:0]        shreg;
  logic [7:0]        code_q;
  logic [7:0]        glyph_next;
  logic              fetch_ok;
  logic              rvalid_q;
  logic [7:0]        rdata_q;

  assign phase    = hpos[2:0];
  assign win_line = (hpos < 11'(H_ACTIVE - 8));
  assign win_next = (hpos >= 11'(H_TOTAL - 8));

  // The last cell slot of a line prefetches column 0 of the following line.
  assign tgt_line = win_next ? ((vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1) : vpos;
  assign tgt_col  = win_next ? '0 : COL_SH'(hpos[10:3] + 8'd1);
  assign active   = (win_line | win_next) && (tgt_line < 10'(V_ACTIVE));

  assign txt_addr = ADDR_W'(TEXT_BASE) + ADDR_W'((32'(tgt_line) >> ROW_SH) << COL_SH)
                  + ADDR_W'(tgt_col);
  assign fnt_addr = ADDR_W'(FONT_BASE) + ADDR_W'(32'(code_q) << ROW_SH)
                  + ADDR_W'(tgt_line & 10'(CELL_H - 1));

  always_comb begin
    slot = FREE;
    if (active) begin
      case (phase)
        3'd0:    slot = TXT_ADDR;
        3'd1:    slot = TXT_DATA;
        3'd2:    slot = FNT_ADDR;
        3'd3:    slot = FNT_DATA;
        default: slot = FREE;
      endcase
    end
  end

  // Display owns the port only on its two address phases; every other cycle goes to the host.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    host_ack  = 1'b0;
    if (rst_n) begin
      if (slot == TXT_ADDR) begin
        mem_en   = 1'b1;
        mem_addr = txt_addr;
      end else if (slot == FNT_ADDR) begin
        mem_en   = 1'b1;
        mem_addr = fnt_addr;
      end else if (host_req) begin
        mem_en    = 1'b1;
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        host_ack  = 1'b1;
      end
    end
  end

  // fetch_ok marks that this slot's text read really happened, so a slot
  // interrupted by reset can never load a half-fetched glyph.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      code_q     <= '0;
      glyph_next <= '0;
      fetch_ok   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rvalid_q <= host_ack & ~host_we;
      if (rvalid_q) rdata_q <= mem_rdata;

      if (phase == 3'd0) begin
        fetch_ok   <= (slot == TXT_ADDR);
        glyph_next <= '0;
      end
      if (slot == TXT_DATA) code_q <= mem_rdata;
      if (slot == FNT_DATA && fetch_ok) glyph_next <= mem_rdata;

      if (phase == 3'd7) shreg <= glyph_next;
      else               shreg <= {shreg[6:0], 1'b0};
    end
  end

  assign pixel_on    = shreg[7] & display_on;
  assign host_rvalid = rvalid_q;
  assign host_rdata  = rvalid_q ? mem_rdata : rdata_q;
  assign slot_state  = slot;

endmodule

// File: tb/tb_glyph_fetch_scheduler.sv
// Directed bench for glyph_fetch_scheduler: bench-side RAM, a spec-level pixel/port model
// checked every cycle, and literal expectations for the named scenarios.
module tb_glyph_fetch_scheduler;

  localparam int H_ACTIVE  = 1024;
  localparam int H_TOTAL   = 1344;
  localparam int V_ACTIVE  = 768;
  localparam int V_TOTAL   = 806;
  localparam int TEXT_BASE = 0;
  localparam int FONT_BASE = 8192;
  localparam int MEM_SIZE  = 16384;
  localparam longint NEVER = 64'h7FFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic [10:0] hpos;
  logic [9:0]  vpos;
  logic        display_on;
  logic        pixel_on;
  logic        mem_en;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        host_req;
  logic        host_we;
  logic [13:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic        host_rvalid;
  logic [7:0]  host_rdata;
  logic [2:0]  slot_state;

  glyph_fetch_scheduler dut (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .pixel_on(pixel_on), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .host_req(host_req),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .slot_state(slot_state)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  longint      cyc      = 0;
  longint      good_t   = NEVER;
  bit          blank_ok = 1'b1;
  bit          exp_rv   = 1'b0;
  bit          ram_init;
  logic [7:0]  ram [0:MEM_SIZE-1];
  logic [7:0]  exp_q [$];

  // ---------------- clock / reset / RAM ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    case (i)
      0:       return 8'h41;
      1:       return 8'h42;
      259:     return 8'h05;
      450:     return 8'h41;
      451:     return 8'h41;
      8279:    return 8'hF0;
      9232:    return 8'h81;
      9234:    return 8'hFF;
      9248:    return 8'h3C;
      default: return (i < FONT_BASE) ? 8'((i * 13 + 7) & 255) : 8'(((i * 29) ^ (i >> 3)) & 255);
    endcase
  endfunction

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < MEM_SIZE; i++) ram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // ---------------- behavioural model ----------------
  function automatic int text_addr(input int line, input int col);
    return (TEXT_BASE + (line / 16) * 128 + col) % MEM_SIZE;
  endfunction

  function automatic int font_addr(input int code, input int line);
    return (FONT_BASE + code * 16 + line % 16) % MEM_SIZE;
  endfunction

  function automatic bit model_pix(input int h, input int v);
    logic [7:0] row;
    if (h >= H_ACTIVE || v >= V_ACTIVE) return 1'b0;
    row = ram[font_addr(int'(ram[text_addr(v, h / 8)]), v)];
    return row[7 - h % 8];
  endfunction

  function automatic void window(input int h, input int v, output bit act,
                                 output int line, output int col);
    act = 1'b0; line = v; col = 0;
    if (h < H_ACTIVE - 8) begin
      line = v; col = h / 8 + 1; act = (line < V_ACTIVE);
    end else if (h >= H_TOTAL - 8) begin
      line = (v == V_TOTAL - 1) ? 0 : v + 1; col = 0; act = (line < V_ACTIVE);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t hpos=%0d vpos=%0d: got %0h expected %0h",
               name, $time, hpos, vpos, got, exp);
    end
  endtask

  // ---------------- compare process (every cycle) ----------------
  always @(negedge clk) begin
    int h, v, p, line, col;
    bit act, disp, grant;
    longint fetch_t;
    h = int'(hpos); v = int'(vpos); p = h % 8;
    if (!rst_n) begin
      chk("rst_pixel", 32'(pixel_on), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_host_ack", 32'(host_ack), 0);
      chk("rst_host_rvalid", 32'(host_rvalid), 0);
      exp_q.delete();
      exp_rv   = 1'b0;
      good_t   = NEVER;
      blank_ok = 1'b1;
    end else begin
      if (p == 0 && good_t == NEVER) good_t = cyc;
      fetch_t = cyc - p - 8;
      if (fetch_t >= good_t)  chk("pixel", 32'(pixel_on), 32'(model_pix(h, v)));
      else if (blank_ok)      chk("pixel_blank", 32'(pixel_on), 0);

      chk("host_rvalid", 32'(host_rvalid), 32'(exp_rv));
      if (exp_rv && exp_q.size() > 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("host_rdata", 32'(host_rdata), 32'(e));
      end

      window(h, v, act, line, col);
      disp  = act && (p == 0 || p == 2);
      grant = !disp && host_req;
      chk("slot_busy", 32'(slot_state != 3'd0), 32'(act && p < 4));
      if (disp) begin
        chk("disp_mem_en", 32'(mem_en), 1);
        chk("disp_mem_we", 32'(mem_we), 0);
        chk("disp_host_ack", 32'(host_ack), 0);
        if (p == 0)
          chk("text_addr", 32'(mem_addr), 32'(text_addr(line, col)));
        else if (cyc - p >= good_t)
          chk("font_addr", 32'(mem_addr), 32'(font_addr(int'(ram[text_addr(line, col)]), line)));
      end else if (grant) begin
        chk("host_mem_en", 32'(mem_en), 1);
        chk("host_mem_we", 32'(mem_we), 32'(host_we));
        chk("host_mem_addr", 32'(mem_addr), 32'(host_addr));
        chk("host_ack", 32'(host_ack), 1);
        if (host_we) chk("host_mem_wdata", 32'(mem_wdata), 32'(host_wdata));
      end else begin
        chk("idle_mem_en", 32'(mem_en), 0);
        chk("idle_host_ack", 32'(host_ack), 0);
      end
      exp_rv = grant && !host_we;
      if (exp_rv) exp_q.push_back(ram[host_addr]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_disp();
    display_on = (hpos < 11'(H_ACTIVE)) && (vpos < 10'(V_ACTIVE));
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (hpos == 11'(H_TOTAL - 1)) begin
      hpos = 11'd0;
      vpos = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
    end else begin
      hpos = hpos + 11'd1;
    end
    set_disp();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic jump(input int v, input int h);
    @(posedge clk); #1;
    vpos = 10'(v); hpos = 11'(h);
    set_disp();
    good_t   = NEVER;
    blank_ok = 1'b0;
  endtask

  task automatic grab(output logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      #1 b[7 - i] = pixel_on;
      step();
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [7:0] b;
    int acks, disp_hits;
    rst_n = 1'b0; hpos = '0; vpos = '0; display_on = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 14'd5; host_wdata = 8'h11;
    repeat (3) @(posedge clk);
    #3;
    chk("reset_pixel_on", 32'(pixel_on), 0);
    chk("reset_mem_en", 32'(mem_en), 0);
    chk("reset_mem_we", 32'(mem_we), 0);
    chk("reset_host_ack", 32'(host_ack), 0);
    chk("reset_host_rvalid", 32'(host_rvalid), 0);
    chk("reset_host_rdata", 32'(host_rdata), 0);
    host_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Frame wrap and single glyph: last cell slot of line 805 fetches line 0 column 0.
    jump(805, 1328);
    run(8);
    #1 chk("wrap_text_en", 32'(mem_en), 1);
    chk("wrap_text_addr", 32'(mem_addr), 0);
    run(2);
    #1 chk("wrap_font_addr", 32'(mem_addr), 9232);
    run(6);
    grab(b); chk("glyph_cell0", 32'(b), 32'h81);
    grab(b); chk("glyph_cell1", 32'(b), 32'h3C);

    // Row/line addressing: line 39 = text row 2, font row 7, column 3.
    jump(39, 8);
    run(8);
    #1 chk("row_text_addr", 32'(mem_addr), 259);
    run(2);
    #1 chk("row_font_addr", 32'(mem_addr), 8279);
    run(6);
    grab(b); chk("row_pixels", 32'(b), 32'hF0);

    // Host contention against the display address phases.
    jump(100, 0);
    run(8);
    host_req = 1'b1; host_we = 1'b1; host_addr = 14'd100; host_wdata = 8'hAA;
    #1 chk("host_wait_p0", 32'(host_ack), 0);
    step();
    #1 chk("host_ack_p1", 32'(host_ack), 1);
    step();
    host_we = 1'b0;
    #1 chk("host_wait_p2", 32'(host_ack), 0);
    step();
    #1 chk("host_ack_p3", 32'(host_ack), 1);
    step();
    host_req = 1'b0;
    #1 chk("host_rvalid_p4", 32'(host_rvalid), 1);
    chk("host_rdata_p4", 32'(host_rdata), 32'hAA);
    run(12);

    // Vertical blanking: every cycle belongs to the host.
    jump(780, 0);
    acks = 0; disp_hits = 0;
    host_req = 1'b1; host_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      host_addr = 14'((i * 97 + 3) % MEM_SIZE);
      #1;
      if (host_ack) acks++;
      if (mem_en && !host_ack) disp_hits++;
      step();
    end
    host_req = 1'b0;
    chk("blank_ack_count", 32'(acks), 40);
    chk("blank_display_fetches", 32'(disp_hits), 0);
    run(4);

    // Asynchronous reset mid-line with a host read in flight.
    jump(50, 496);
    run(18);
    host_req = 1'b1; host_we = 1'b0; host_addr = 14'd451;
    step();
    #1 rst_n = 1'b0;
    #1 chk("async_pixel_on", 32'(pixel_on), 0);
    chk("async_host_ack", 32'(host_ack), 0);
    chk("async_host_rvalid", 32'(host_rvalid), 0);
    chk("async_mem_en", 32'(mem_en), 0);
    host_req = 1'b0;
    run(8);
    rst_n = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 14'd451;
    #1 chk("release_host_ack", 32'(host_ack), 1);
    step();
    host_req = 1'b0;
    #1 chk("release_rvalid", 32'(host_rvalid), 1);
    chk("release_rdata", 32'(host_rdata), 32'h41);
    run(4);
    grab(b); chk("release_cell_blank", 32'(b), 32'h00);
    grab(b); chk("release_cell_next", 32'(b), 32'hFF);
    run(16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
